// File: rtl/aes_host_pkg.sv
// Shared types for the AES block-stream host.
// Block width, block type and host FSM state encoding.
package aes_host_pkg;

  localparam int AES_BLOCK_W = 128;

  typedef logic [AES_BLOCK_W-1:0] aes_block_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOADKEY = 3'd1,
    WAITKEY = 3'd2,
    FEED    = 3'd3,
    ISSUE   = 3'd4,
    WAITOUT = 3'd5,
    FINISH  = 3'd6
  } host_state_e;

endpackage

// File: rtl/aes_cbc_host_if.sv
// Bus bundle between the stream fabric, the AES core and aes_cbc_host.
// master = host side, slave = environment (fabric + core) side.
interface aes_cbc_host_if;
  import aes_host_pkg::*;

  logic       start_i;
  logic       decrypt_i;
  aes_block_t key_i;
  aes_block_t iv_i;

  logic       s_valid_i;
  logic       s_ready_o;
  aes_block_t s_data_i;
  logic       s_last_i;

  logic       m_valid_o;
  logic       m_ready_i;
  aes_block_t m_data_o;
  logic       m_last_o;

  logic       core_load_key_o;
  aes_block_t core_key_o;
  logic       core_decrypt_o;
  logic       core_valid_o;
  logic       core_ready_i;
  aes_block_t core_data_o;
  logic       core_valid_i;
  aes_block_t core_data_i;

  logic       busy_o;
  logic       done_o;

  modport master (
    input  start_i, decrypt_i, key_i, iv_i,
    input  s_valid_i, s_data_i, s_last_i,
    input  m_ready_i,
    input  core_ready_i, core_valid_i, core_data_i,
    output s_ready_o,
    output m_valid_o, m_data_o, m_last_o,
    output core_load_key_o, core_key_o,
    output core_decrypt_o, core_valid_o, core_data_o,
    output busy_o, done_o
  );

  modport slave (
    output start_i, decrypt_i, key_i, iv_i,
    output s_valid_i, s_data_i, s_last_i,
    output m_ready_i,
    output core_ready_i, core_valid_i, core_data_i,
    input  s_ready_o,
    input  m_valid_o, m_data_o, m_last_o,
    input  core_load_key_o, core_key_o,
    input  core_decrypt_o, core_valid_o, core_data_o,
    input  busy_o, done_o
  );

endinterface

// File: rtl/aes_cbc_host.sv
// Block-at-a-time AES core initiator with CBC chaining.
// Define AES_CBC_EN for CBC; undefined builds plain ECB.
module aes_cbc_host
  import aes_host_pkg::*;
(
  input logic            clk_i,
  input logic            rst_i,
  aes_cbc_host_if.master bus
);

  host_state_e state_q;
  aes_block_t  key_q;
  aes_block_t  core_q;
  aes_block_t  m_data_q;
  logic        dec_q;
  logic        last_q;
  logic        m_valid_q;
  logic        m_last_q;

`ifdef AES_CBC_EN
  aes_block_t  chain_q;
  aes_block_t  pend_q;
`else
  logic        unused_iv;
  assign unused_iv = ^bus.iv_i;
`endif

  logic s_ready;
  logic s_fire;
  logic m_fire;
  logic drained;

  assign s_ready = (state_q == FEED) & bus.core_ready_i
                 & ~m_valid_q;
  assign s_fire  = bus.s_valid_i & s_ready;
  assign m_fire  = m_valid_q & bus.m_ready_i;
  assign drained = ~m_valid_q | bus.m_ready_i;

  assign bus.s_ready_o       = s_ready;
  assign bus.m_valid_o       = m_valid_q;
  assign bus.m_data_o        = m_data_q;
  assign bus.m_last_o        = m_last_q;
  assign bus.core_load_key_o = (state_q == LOADKEY);
  assign bus.core_key_o      = key_q;
  assign bus.core_decrypt_o  = dec_q;
  assign bus.core_valid_o    = (state_q == ISSUE);
  assign bus.core_data_o     = core_q;
  assign bus.busy_o          = (state_q != IDLE);
  assign bus.done_o          = (state_q == FINISH) & drained;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      key_q     <= '0;
      core_q    <= '0;
      m_data_q  <= '0;
      dec_q     <= 1'b0;
      last_q    <= 1'b0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
`ifdef AES_CBC_EN
      chain_q   <= '0;
      pend_q    <= '0;
`endif
    end else begin
      if (m_fire) m_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start_i) begin
            key_q   <= bus.key_i;
            dec_q   <= bus.decrypt_i;
`ifdef AES_CBC_EN
            chain_q <= bus.iv_i;
`endif
            state_q <= LOADKEY;
          end
        end
        LOADKEY: state_q <= WAITKEY;
        WAITKEY: begin
          if (bus.core_ready_i) state_q <= FEED;
        end
        FEED: begin
          if (s_fire) begin
`ifdef AES_CBC_EN
            // decrypt chains on the ciphertext, so keep it
            core_q <= dec_q ? bus.s_data_i
                            : bus.s_data_i ^ chain_q;
            pend_q <= bus.s_data_i;
`else
            core_q <= bus.s_data_i;
`endif
            last_q  <= bus.s_last_i;
            state_q <= ISSUE;
          end
        end
        ISSUE: state_q <= WAITOUT;
        WAITOUT: begin
          if (bus.core_valid_i) begin
            m_valid_q <= 1'b1;
            m_last_q  <= last_q;
`ifdef AES_CBC_EN
            m_data_q <= dec_q ? bus.core_data_i ^ chain_q
                              : bus.core_data_i;
            chain_q  <= dec_q ? pend_q : bus.core_data_i;
`else
            m_data_q <= bus.core_data_i;
`endif
            state_q <= last_q ? FINISH : FEED;
          end
        end
        FINISH: begin
          if (drained) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_cbc_host.sv
// Bench for aes_cbc_host with a behavioural AES-128 core model.
// Reference: FIPS-197 AES plus CBC/ECB chaining from message rules.
module tb_aes_cbc_host;
  import aes_host_pkg::*;

  typedef aes_block_t blk_q_t[$];

`ifdef AES_CBC_EN
  localparam bit CBC = 1'b1;
`else
  localparam bit CBC = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   load_cnt = 0;
  int   issue_cnt = 0;
  int   done_cnt = 0;

  logic [7:0] sb  [256];
  logic [7:0] isb [256];

  aes_cbc_host_if bus();

  aes_cbc_host dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a,
                                    input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] x;
    r = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r ^= x;
      x = xt(x);
    end
    return r;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
        ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sb[x]  = s;
      isb[s] = 8'(x);
    end
  endtask

  function automatic logic [7:0] gb(input aes_block_t b, input int i);
    return b[127-8*i -: 8];
  endfunction

  function automatic aes_block_t rkey(input aes_block_t key,
                                      input int r);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]}
          ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic aes_block_t sub_b(input aes_block_t b,
                                       input bit inv);
    aes_block_t o;
    o = '0;
    for (int i = 0; i < 16; i++)
      o[127-8*i -: 8] = inv ? isb[gb(b, i)] : sb[gb(b, i)];
    return o;
  endfunction

  function automatic aes_block_t shift_r(input aes_block_t b,
                                         input bit inv);
    aes_block_t o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!inv) o[127-8*(4*c+r) -: 8] = gb(b, 4*((c+r)%4)+r);
        else o[127-8*(4*((c+r)%4)+r) -: 8] = gb(b, 4*c+r);
    return o;
  endfunction

  function automatic aes_block_t mix_c(input aes_block_t b,
                                       input bit inv);
    aes_block_t o;
    logic [7:0] cf [4];
    logic [7:0] v;
    o = '0;
    cf[0] = inv ? 8'd14 : 8'd2;
    cf[1] = inv ? 8'd11 : 8'd3;
    cf[2] = inv ? 8'd13 : 8'd1;
    cf[3] = inv ? 8'd9  : 8'd1;
    for (int c = 0; c < 4; c++)
      for (int j = 0; j < 4; j++) begin
        v = 8'h00;
        for (int i = 0; i < 4; i++)
          v ^= gm(cf[(i-j+4)%4], gb(b, 4*c+i));
        o[127-8*(4*c+j) -: 8] = v;
      end
    return o;
  endfunction

  function automatic aes_block_t aes_enc(input aes_block_t k,
                                         input aes_block_t p);
    aes_block_t s;
    s = p ^ rkey(k, 0);
    for (int r = 1; r < 10; r++)
      s = mix_c(shift_r(sub_b(s, 0), 0), 0) ^ rkey(k, r);
    return shift_r(sub_b(s, 0), 0) ^ rkey(k, 10);
  endfunction

  function automatic aes_block_t aes_dec(input aes_block_t k,
                                         input aes_block_t c);
    aes_block_t s;
    s = c ^ rkey(k, 10);
    for (int r = 9; r > 0; r--)
      s = mix_c(sub_b(shift_r(s, 1), 1) ^ rkey(k, r), 1);
    return sub_b(shift_r(s, 1), 1) ^ rkey(k, 0);
  endfunction

  // Message-level reference: chaining from the mode rules only.
  function automatic blk_q_t ref_model(input logic dec,
                                       input aes_block_t key,
                                       input aes_block_t iv,
                                       input blk_q_t blks);
    blk_q_t o;
    aes_block_t prev;
    aes_block_t mask;
    prev = iv;
    foreach (blks[i]) begin
      mask = CBC ? prev : '0;
      if (!dec) begin
        prev = aes_enc(key, blks[i] ^ mask);
        o.push_back(prev);
      end else begin
        o.push_back(aes_dec(key, blks[i]) ^ mask);
        prev = blks[i];
      end
    end
    return o;
  endfunction

  function automatic aes_block_t rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  // AES core model: key setup delay, 2..5 cycle block latency,
  // result pulse without backpressure.
  initial begin : core_model
    aes_block_t ck;
    aes_block_t res;
    int         kcnt;
    int         lcnt;
    bit         cbusy;
    ck = '0;
    res = '0;
    kcnt = 0;
    lcnt = 0;
    cbusy = 1'b0;
    bus.core_ready_i = 1'b0;
    bus.core_valid_i = 1'b0;
    bus.core_data_i  = '0;
    forever begin
      @(negedge clk);
      bus.core_valid_i = 1'b0;
      if (bus.core_load_key_o) begin
        load_cnt++;
        ck = bus.core_key_o;
        kcnt = 3;
      end else if (kcnt > 0) begin
        kcnt--;
      end
      if (bus.core_valid_o) begin
        issue_cnt++;
        cbusy = 1'b1;
        lcnt = int'($urandom_range(2, 5));
        res = bus.core_decrypt_o ? aes_dec(ck, bus.core_data_o)
                                 : aes_enc(ck, bus.core_data_o);
      end else if (cbusy) begin
        lcnt--;
        if (lcnt == 0) begin
          cbusy = 1'b0;
          bus.core_valid_i = 1'b1;
          bus.core_data_i  = res;
        end
      end
      bus.core_ready_i = (kcnt == 0) && !cbusy;
    end
  end

  initial begin : done_mon
    forever begin
      @(negedge clk);
      #2;
      if (bus.done_o === 1'b1) begin
        done_cnt++;
        checks++;
        if (bus.m_valid_o === 1'b1 && bus.m_ready_i !== 1'b1) begin
          errors++;
          $display("FAIL done_order: done_o=1 with m_valid_o=1 m_ready_i=%b, required output drained",
                   bus.m_ready_i);
        end
      end
    end
  end

  task automatic run_msg(input string nm, input logic dec,
                         input aes_block_t key, input aes_block_t iv,
                         input blk_q_t blks, input blk_q_t want,
                         input int stall_at, input int stall_len,
                         input bit poke_start);
    int n;
    int t;
    int ld0;
    int is0;
    int d0;
    n = blks.size();
    ld0 = load_cnt;
    is0 = issue_cnt;
    d0 = done_cnt;
    bus.decrypt_i = dec;
    bus.key_i = key;
    bus.iv_i = iv;
    bus.start_i = 1'b1;
    cyc();
    bus.start_i = 1'b0;
    bus.key_i = rnd128();
    bus.iv_i = rnd128();
    bus.decrypt_i = ~dec;
    for (int i = 0; i < n; i++) begin
      bus.s_valid_i = 1'b1;
      bus.s_data_i = blks[i];
      bus.s_last_i = (i == n - 1);
      t = 0;
      while (bus.s_ready_o !== 1'b1 && t < 100) begin
        cyc();
        t++;
      end
      checks++;
      if (t >= 100) begin
        errors++;
        $display("FAIL %s_accept[%0d]: s_ready_o=%b, required 1 within 100 cycles",
                 nm, i, bus.s_ready_o);
        bus.s_valid_i = 1'b0;
        return;
      end
      cyc();
      if (i + 1 < n) begin
        bus.s_data_i = blks[i+1];
        bus.s_last_i = (i + 1 == n - 1);
      end else begin
        bus.s_valid_i = 1'b0;
      end
      t = 0;
      while (bus.m_valid_o !== 1'b1 && t < 100) begin
        cyc();
        t++;
      end
      checks++;
      if (t >= 100) begin
        errors++;
        $display("FAIL %s_out[%0d]: m_valid_o=%b, required 1 within 100 cycles",
                 nm, i, bus.m_valid_o);
        bus.s_valid_i = 1'b0;
        return;
      end
      if (i == stall_at) begin
        for (int k = 0; k < stall_len; k++) begin
          bus.start_i = poke_start && (k == 1);
          if (bus.start_i) bus.key_i = ~key;
          checks++;
          if (bus.m_data_o !== want[i]) begin
            errors++;
            $display("FAIL %s_stall_data[%0d]: m_data_o=%h, required %h",
                     nm, k, bus.m_data_o, want[i]);
          end
          checks++;
          if ({bus.m_valid_o, bus.s_ready_o, bus.core_valid_o} !== 3'b100) begin
            errors++;
            $display("FAIL %s_stall_ctrl[%0d]: m_valid,s_ready,core_valid=%b, required 100",
                     nm, k, {bus.m_valid_o, bus.s_ready_o, bus.core_valid_o});
          end
          cyc();
        end
        bus.start_i = 1'b0;
      end else begin
        repeat (int'($urandom_range(0, 2))) cyc();
      end
      bus.m_ready_i = 1'b1;
      checks++;
      if (bus.m_data_o !== want[i]) begin
        errors++;
        $display("FAIL %s_data[%0d]: m_data_o=%h, required %h",
                 nm, i, bus.m_data_o, want[i]);
      end
      checks++;
      if (bus.m_last_o !== (i == n - 1)) begin
        errors++;
        $display("FAIL %s_last[%0d]: m_last_o=%b, required %b",
                 nm, i, bus.m_last_o, (i == n - 1));
      end
      cyc();
      bus.m_ready_i = 1'b0;
    end
    t = 0;
    while (done_cnt == d0 && t < 20) begin
      cyc();
      t++;
    end
    repeat (3) cyc();
    checks++;
    if (done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL %s_done: done pulses=%0d, required 1",
               nm, done_cnt - d0);
    end
    checks++;
    if (load_cnt - ld0 != 1) begin
      errors++;
      $display("FAIL %s_keyload: key loads=%0d, required 1",
               nm, load_cnt - ld0);
    end
    checks++;
    if (issue_cnt - is0 != n) begin
      errors++;
      $display("FAIL %s_issue: core issues=%0d, required %0d",
               nm, issue_cnt - is0, n);
    end
    checks++;
    if (bus.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: busy_o=%b, required 0", nm, bus.busy_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) cyc();
    checks++;
    if ({bus.s_ready_o, bus.m_valid_o, bus.m_last_o,
         bus.core_load_key_o, bus.core_decrypt_o,
         bus.core_valid_o, bus.busy_o, bus.done_o} !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl: outputs=%b, required 00000000",
               {bus.s_ready_o, bus.m_valid_o, bus.m_last_o,
                bus.core_load_key_o, bus.core_decrypt_o,
                bus.core_valid_o, bus.busy_o, bus.done_o});
    end
    checks++;
    if ({bus.m_data_o, bus.core_key_o, bus.core_data_o} !== '0) begin
      errors++;
      $display("FAIL reset_data: m_data=%h core_key=%h core_data=%h, required 0",
               bus.m_data_o, bus.core_key_o, bus.core_data_o);
    end
    rst = 1'b0;
    repeat (2) cyc();
    checks++;
    if ({bus.busy_o, bus.core_load_key_o} !== 2'b00) begin
      errors++;
      $display("FAIL reset_idle: busy,load_key=%b, required 00",
               {bus.busy_o, bus.core_load_key_o});
    end
  endtask

  task automatic test_ecb_single();
    blk_q_t b;
    blk_q_t w;
    b = {128'h3243f6a8885a308d313198a2e0370734};
    w = {128'h3925841d02dc09fbdc118597196a0b32};
    run_msg("ecb1", 1'b0, 128'h2b7e151628aed2a6abf7158809cf4f3c,
            '0, b, w, -1, 0, 1'b0);
  endtask

  task automatic test_cbc_encrypt();
    blk_q_t b;
    blk_q_t w;
    aes_block_t key;
    aes_block_t iv;
    key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    iv = 128'h000102030405060708090a0b0c0d0e0f;
    b = {128'h6bc1bee22e409f96e93d7e117393172a,
         128'hae2d8a571e03ac9c9eb76fac45af8e51};
    if (CBC) w = {128'h7649abac8119b246cee98e9b12e9197d,
                  128'h5086cb9b507219ee95db113a917678b2};
    else w = ref_model(1'b0, key, iv, b);
    run_msg("cbc_enc", 1'b0, key, iv, b, w, -1, 0, 1'b0);
  endtask

  task automatic test_cbc_decrypt();
    blk_q_t b;
    blk_q_t w;
    aes_block_t key;
    aes_block_t iv;
    key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    iv = 128'h000102030405060708090a0b0c0d0e0f;
    b = {128'h7649abac8119b246cee98e9b12e9197d,
         128'h5086cb9b507219ee95db113a917678b2};
    if (CBC) w = {128'h6bc1bee22e409f96e93d7e117393172a,
                  128'hae2d8a571e03ac9c9eb76fac45af8e51};
    else w = ref_model(1'b1, key, iv, b);
    run_msg("cbc_dec", 1'b1, key, iv, b, w, -1, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    blk_q_t b;
    aes_block_t key;
    aes_block_t iv;
    key = rnd128();
    iv = rnd128();
    b = {rnd128(), rnd128()};
    run_msg("bp", 1'b0, key, iv, b, ref_model(1'b0, key, iv, b),
            0, 20, 1'b0);
  endtask

  task automatic test_ignored_start();
    blk_q_t b;
    aes_block_t key;
    aes_block_t iv;
    key = rnd128();
    iv = rnd128();
    b = {rnd128(), rnd128()};
    run_msg("ign_start", 1'b1, key, iv, b,
            ref_model(1'b1, key, iv, b), 0, 4, 1'b1);
  endtask

  task automatic test_reset_mid();
    int t;
    bit seen;
    bus.key_i = rnd128();
    bus.iv_i = rnd128();
    bus.decrypt_i = 1'b1;
    bus.start_i = 1'b1;
    cyc();
    bus.start_i = 1'b0;
    bus.s_valid_i = 1'b1;
    bus.s_data_i = rnd128();
    bus.s_last_i = 1'b0;
    t = 0;
    while (bus.core_valid_o !== 1'b1 && t < 100) begin
      cyc();
      t++;
    end
    bus.s_valid_i = 1'b0;
    checks++;
    if (t >= 100) begin
      errors++;
      $display("FAIL rst_mid_issue: core_valid_o=%b, required 1 within 100 cycles",
               bus.core_valid_o);
    end
    cyc();
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.s_ready_o, bus.m_valid_o, bus.m_last_o,
         bus.core_load_key_o, bus.core_decrypt_o,
         bus.core_valid_o, bus.busy_o, bus.done_o} !== 8'h00) begin
      errors++;
      $display("FAIL rst_mid_ctrl: outputs=%b, required 00000000",
               {bus.s_ready_o, bus.m_valid_o, bus.m_last_o,
                bus.core_load_key_o, bus.core_decrypt_o,
                bus.core_valid_o, bus.busy_o, bus.done_o});
    end
    checks++;
    if ({bus.m_data_o, bus.core_key_o, bus.core_data_o} !== '0) begin
      errors++;
      $display("FAIL rst_mid_data: m_data=%h core_key=%h core_data=%h, required 0",
               bus.m_data_o, bus.core_key_o, bus.core_data_o);
    end
    cyc();
    rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      cyc();
      if (bus.m_valid_o !== 1'b0 || bus.busy_o !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL rst_mid_stale: m_valid_o/busy_o rose after reset, required 0");
    end
  endtask

  task automatic test_random();
    blk_q_t b;
    aes_block_t key;
    aes_block_t iv;
    logic dec;
    int n;
    for (int m = 0; m < 6; m++) begin
      dec = 1'($urandom_range(0, 1));
      n = int'($urandom_range(1, 4));
      key = rnd128();
      iv = rnd128();
      b.delete();
      for (int i = 0; i < n; i++) b.push_back(rnd128());
      run_msg("rand", dec, key, iv, b, ref_model(dec, key, iv, b),
              int'($urandom_range(0, n - 1)),
              int'($urandom_range(0, 5)), 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.start_i = 1'b0;
    bus.decrypt_i = 1'b0;
    bus.key_i = '0;
    bus.iv_i = '0;
    bus.s_valid_i = 1'b0;
    bus.s_data_i = '0;
    bus.s_last_i = 1'b0;
    bus.m_ready_i = 1'b0;
    build_sbox();
    test_reset();
    test_ecb_single();
    test_cbc_encrypt();
    test_cbc_decrypt();
    test_backpressure();
    test_ignored_start();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_cbc_host.md
# aes_cbc_host

- Initiator that drives `AES_top_mod` through its key-load and block handshake.
- Accepts a stream of 128-bit blocks on an upstream valid/ready port and applies CBC chaining for both directions.
- Issues one block at a time to the core, captures the core's non-backpressured result, and presents it on a downstream valid/ready port.
- Sits between the system stream fabric and the AES core.

## Interface
Parameters:
- none.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: reset. One clock; reset is asynchronous and active-high.
- `start_i` in 1: one-cycle pulse that starts a message. Samples `decrypt_i`, `key_i` and `iv_i`.
- `decrypt_i` in 1: direction; 1 = decrypt.
- `key_i` in 128: cipher key.
- `iv_i` in 128: initialisation vector.
- `s_valid_i` in 1, `s_ready_o` out 1: upstream block handshake.
- `s_data_i` in 128, `s_last_i` in 1: upstream block and end-of-message flag.
- `m_valid_o` out 1, `m_ready_i` in 1: downstream block handshake.
- `m_data_o` out 128, `m_last_o` out 1: downstream block and end-of-message flag.
- `core_load_key_o` out 1, `core_key_o` out 128: key load to the core.
- `core_decrypt_o` out 1: direction to the core.
- `core_valid_o` out 1, `core_ready_i` in 1, `core_data_o` out 128: block issue to the core.
- `core_valid_i` in 1, `core_data_i` in 128: core result. The core has no backpressure.
- `busy_o` out 1: high in any state except IDLE.
- `done_o` out 1: one-cycle pulse at end of message.

## Operation
States: IDLE, LOADKEY, WAITKEY, FEED, ISSUE, WAITOUT, FINISH.
- **IDLE:** on `start_i`, latch key into `key_q`, IV into `chain_q`, direction into `dec_q`; go to LOADKEY. `start_i` in any other state is ignored.
- **LOADKEY:** `core_load_key_o`=1 for exactly one cycle, with `core_key_o`=`key_q`; go to WAITKEY.
- **WAITKEY:** wait for `core_ready_i`=1, then go to FEED.
- **FEED:** `s_ready_o` = `core_ready_i` & !`m_valid_o`. On handshake:
  - Encrypt: `core_q` = `s_data_i` ^ `chain_q`.
  - Decrypt: `core_q` = `s_data_i`, and `s_data_i` is saved to `pend_q`.
  - Latch `s_last_i` into `last_q`; go to ISSUE.
- **ISSUE:** `core_valid_o`=1 for exactly one cycle, `core_data_o`=`core_q`; go to WAITOUT.
- **WAITOUT:** on `core_valid_i`, load the output register and set `m_valid_o`=1, `m_last_o`=`last_q`.
  - Encrypt: `m_data_o` = `core_data_i`, then `chain_q` = `core_data_i`.
  - Decrypt: `m_data_o` = `core_data_i` ^ `chain_q`, then `chain_q` = `pend_q`.
  - Next state is FINISH if `last_q`, else FEED.
- **FINISH:** wait until the output register drains (`m_valid_o`=0 or the handshake occurs this cycle). Pulse `done_o` for one cycle, then go to IDLE.
- **Output register:** one entry. It clears on `m_valid_o` & `m_ready_i`. Because a block is accepted in FEED only when the register is empty, the register can never be overwritten.
- **Stray `core_valid_i`:** ignored outside WAITOUT. This includes a result still in flight from before a reset.
- **Reset mid-message:** every register clears and the FSM returns to IDLE. Any partially processed block is discarded.
- **XOR width:** all XOR is full 128-bit with no truncation. `core_decrypt_o` = `dec_q`.

## Timing
- **Reset values:** every output is 0, including all data buses, and the state is IDLE.
- **Start to first acceptance:** `start_i` at cycle t gives `core_load_key_o` at t+1. The earliest `s_ready_o` is the cycle after `core_ready_i` is seen in WAITKEY.
- **Block latency:** upstream handshake at t gives `core_valid_o` at t+1. `core_valid_i` at t+1+L, where L is the core latency, gives `m_valid_o` at t+2+L.
- **Throughput:** at most one block in flight. The next `s_ready_o` can occur no earlier than the cycle after `m_valid_o` falls.
- **Downstream stall:** `m_data_o` and `m_last_o` hold stable while `m_valid_o` & !`m_ready_i`.
- **Upstream stall:** `s_ready_o` never depends on `s_valid_i`.
- **Ordering:** `done_o` never asserts before the last block's downstream handshake.

## Configuration
- `AES_CBC_EN` defined: CBC chaining as described above.
- Undefined: ECB mode.
  - `chain_q` and `pend_q` are removed.
  - `core_q` = `s_data_i` and `m_data_o` = `core_data_i`.
  - `iv_i` is ignored. The ports are unchanged.

## Structure
- Package `aes_host_pkg`: `aes_block_t` (logic [127:0]), state enum `host_state_e`, localparam `AES_BLOCK_W` = 128.
- Single module, no sub-module. The chaining XOR and the output register are too small to split out.

## Test plan
Use a `AES_top_mod` instance as the core in all scenarios.
- **ECB, single block** (`AES_CBC_EN` undefined): key 2b7e151628aed2a6abf7158809cf4f3c, block 3243f6a8885a308d313198a2e0370734 with last=1 -> `m_data_o` 3925841d02dc09fbdc118597196a0b32, `m_last_o`=1, one `done_o` pulse.
- **CBC encrypt, two blocks:** same key, IV 000102030405060708090a0b0c0d0e0f, blocks 6bc1bee22e409f96e93d7e117393172a and ae2d8a571e03ac9c9eb76fac45af8e51 -> outputs 7649abac8119b246cee98e9b12e9197d then 5086cb9b507219ee95db113a917678b2.
- **CBC decrypt:** the two ciphertexts above with the same IV -> the original plaintexts, in order.
- **Downstream backpressure:** hold `m_ready_i`=0 for 20 cycles after the first output -> `m_data_o` stable, `s_ready_o`=0 throughout, no `core_valid_o`; the second block completes correctly after release.
- **Reset mid-message:** assert `rst_i` in WAITOUT -> all outputs 0, state IDLE; the stale core result is ignored (`m_valid_o` stays 0).
- **Ignored start:** `start_i` pulse while busy -> no extra `core_load_key_o` and output unchanged.
